// File: rtl/pmc_frame_encoder.sv
// PMC frame encoder: latches one transaction result into a 96-bit frame and
// streams it MSB byte first to a byte-wide UART transmitter over valid/ready.
module pmc_frame_encoder #(
  parameter logic [7:0]  START_BYTE = 8'h0F,
  parameter logic [7:0]  END_BYTE   = 8'hF0,
  parameter logic [15:0] HDR_READ   = 16'h0001,
  parameter logic [15:0] HDR_WRITE  = 16'h0002,
  parameter logic [7:0]  ERR_CODE   = 8'h01,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iReq,
  input  logic        iRead,
  input  logic        iWrite,
  input  logic [23:0] iAddr,
  input  logic [31:0] iData,
  input  logic        iError,
  output logic        oReady,
  output logic [95:0] oMsg,
  output logic [7:0]  oTxByte,
  output logic        oTxValid,
  input  logic        iTxReady,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE,
    GAP
  } state_t;

  localparam logic [7:0] GAP_LOAD = GAP_CYCLES[7:0];
  localparam logic [3:0] LAST_IDX = 4'd11;

  state_t      state;
  state_t      state_next;
  logic [3:0]  idx;
  logic [3:0]  idx_next;
  logic [3:0]  idx_dec;
  logic [7:0]  gap_cnt;
  logic [7:0]  gap_next;
  logic [95:0] msg_next;
  logic [7:0]  byte_next;
  logic        valid_next;
  logic        done_next;

  logic        is_read;
  logic        is_write;
  logic [15:0] header;
  logic [7:0]  err_byte;
  logic [95:0] new_frame;
  logic        transfer;
  logic [7:0]  following_byte;

  // Ambiguous operations (both or neither of read/write) carry an empty
  // header and are always flagged as errors so the far end rejects them.
  assign is_read   = iRead & ~iWrite;
  assign is_write  = iWrite & ~iRead;
  assign header    = is_read ? HDR_READ : (is_write ? HDR_WRITE : 16'h0000);
  assign err_byte  = (iError | (iRead == iWrite)) ? ERR_CODE : 8'h00;
  assign new_frame = {START_BYTE, header, iData, iAddr, err_byte, END_BYTE};

  assign transfer       = oTxValid & iTxReady;
  assign idx_dec        = idx - 4'd1;
  assign following_byte = oMsg[{idx_dec, 3'b000} +: 8];

  assign oReady = (state == IDLE);
  assign oBusy  = (state != IDLE);

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    msg_next   = oMsg;
    byte_next  = oTxByte;
    valid_next = oTxValid;
    done_next  = 1'b0;
    idx_next   = idx;
    gap_next   = gap_cnt;

    case (state)
      IDLE: begin
        if (iReq) begin
          msg_next   = new_frame;
          byte_next  = START_BYTE;
          valid_next = 1'b1;
          idx_next   = LAST_IDX;
          state_next = SEND;
        end
      end
      SEND: begin
        if (transfer) begin
          if (idx != 4'd0) begin
            idx_next  = idx_dec;
            byte_next = following_byte;
          end else begin
            valid_next = 1'b0;
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (GAP_LOAD == 8'd0) begin
          state_next = IDLE;
        end else begin
          gap_next   = GAP_LOAD;
          state_next = GAP;
        end
      end
      GAP: begin
        gap_next = gap_cnt - 8'd1;
        if (gap_cnt == 8'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      oMsg     <= '0;
      oTxByte  <= '0;
      oTxValid <= 1'b0;
      oDone    <= 1'b0;
      idx      <= LAST_IDX;
      gap_cnt  <= '0;
    end else begin
      state    <= state_next;
      oMsg     <= msg_next;
      oTxByte  <= byte_next;
      oTxValid <= valid_next;
      oDone    <= done_next;
      idx      <= idx_next;
      gap_cnt  <= gap_next;
    end
  end

endmodule

// File: tb/tb_pmc_frame_encoder.sv
// Self-checking bench for pmc_frame_encoder: directed scenarios plus random
// frames compared against a frame-level reference model.
module tb_pmc_frame_encoder;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic        req3;
  logic        rd;
  logic        wr;
  logic [23:0] addr;
  logic [31:0] data;
  logic        err;
  logic        tx_ready;

  logic        ready0, txv0, busy0, done0;
  logic [95:0] msg0;
  logic [7:0]  txb0;
  logic        ready3, txv3, busy3, done3;
  logic [95:0] msg3;
  logic [7:0]  txb3;

  int checks;
  int failures;

  pmc_frame_encoder dut (
    .clk(clk), .reset(rst_n), .iReq(req0), .iRead(rd), .iWrite(wr),
    .iAddr(addr), .iData(data), .iError(err), .oReady(ready0), .oMsg(msg0),
    .oTxByte(txb0), .oTxValid(txv0), .iTxReady(tx_ready), .oBusy(busy0),
    .oDone(done0)
  );

  pmc_frame_encoder #(.GAP_CYCLES(3)) dut_gap (
    .clk(clk), .reset(rst_n), .iReq(req3), .iRead(rd), .iWrite(wr),
    .iAddr(addr), .iData(data), .iError(err), .oReady(ready3), .oMsg(msg3),
    .oTxByte(txb3), .oTxValid(txv3), .iTxReady(tx_ready), .oBusy(busy3),
    .oDone(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: frame assembled straight from the field rules.
  function automatic logic [95:0] model_frame(input logic r, input logic w,
                                              input logic [23:0] a,
                                              input logic [31:0] d,
                                              input logic e);
    logic [15:0] h;
    logic [7:0]  eb;
    if (r && !w)      h = 16'h0001;
    else if (w && !r) h = 16'h0002;
    else              h = 16'h0000;
    eb = (e || (r == w)) ? 8'h01 : 8'h00;
    return {8'h0F, h, d, a, eb, 8'hF0};
  endfunction

  function automatic logic [7:0] frame_byte(input logic [95:0] f, input int k);
    logic [95:0] sh;
    sh = f >> (8 * (11 - k));
    return sh[7:0];
  endfunction

  // Sends one frame through dut; mode 0 = always ready, 1 = 1,0,0 pattern,
  // 2 = random ready. With mutate, request and inputs churn during the frame.
  task automatic run_frame(input logic r, input logic w, input logic [23:0] a,
                           input logic [31:0] d, input logic e, input int mode,
                           input bit mutate, input string tag);
    logic [95:0] exp;
    int k;
    int cyc;
    exp = model_frame(r, w, a, d, e);
    cyc = 0;
    while (ready0 !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ready0 !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept got=%b want=1", tag, ready0);
    end
    rd = r; wr = w; addr = a; data = d; err = e; req0 = 1'b1;
    tx_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (!mutate) req0 = 1'b0;
    checks++;
    if (msg0 !== exp) begin
      failures++;
      $display("FAIL %s msg got=%h want=%h", tag, msg0, exp);
    end
    checks++;
    if ({ready0, busy0} !== 2'b01) begin
      failures++;
      $display("FAIL %s ready_busy_after_accept got=%b want=01", tag, {ready0, busy0});
    end
    k = 0;
    cyc = 0;
    while (k < 12 && cyc < 400) begin
      checks++;
      if ({txv0, txb0} !== {1'b1, frame_byte(exp, k)}) begin
        failures++;
        $display("FAIL %s byte%0d got=%b/%h want=1/%h", tag, k, txv0, txb0,
                 frame_byte(exp, k));
      end
      if (mutate) begin
        checks++;
        if (ready0 !== 1'b0) begin
          failures++;
          $display("FAIL %s ready_mid_frame got=%b want=0", tag, ready0);
        end
        addr = 24'($urandom); data = $urandom;
        rd = 1'($urandom); wr = 1'($urandom); err = 1'($urandom);
      end
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      if (tx_ready) k++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (k != 12) begin
      failures++;
      $display("FAIL %s transfer_count got=%0d want=12", tag, k);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != 12) begin
        failures++;
        $display("FAIL %s back_to_back_cycles got=%0d want=12", tag, cyc);
      end
    end
    tx_ready = 1'($urandom_range(0, 1));
    checks++;
    if ({done0, txv0, busy0, ready0} !== 4'b1010) begin
      failures++;
      $display("FAIL %s done_cycle done/valid/busy/ready got=%b want=1010", tag,
               {done0, txv0, busy0, ready0});
    end
    checks++;
    if (msg0 !== exp) begin
      failures++;
      $display("FAIL %s msg_held got=%h want=%h", tag, msg0, exp);
    end
    @(negedge clk);
    checks++;
    if ({done0, busy0, ready0} !== 3'b001) begin
      failures++;
      $display("FAIL %s after_done done/busy/ready got=%b want=001", tag,
               {done0, busy0, ready0});
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({ready0, txv0, busy0, done0, txb0, msg0} !== {4'b1000, 8'h00, 96'h0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b v=%b b=%b d=%b byte=%h msg=%h want 1,0,0,0,00,0",
               ready0, txv0, busy0, done0, txb0, msg0);
    end
  endtask

  task automatic test_read_frame();
    run_frame(1'b1, 1'b0, 24'h123456, 32'hDEADBEEF, 1'b0, 0, 1'b0, "read");
    checks++;
    if (msg0 !== 96'h0F0001DEADBEEF12345600F0) begin
      failures++;
      $display("FAIL read_msg_const got=%h want=0f0001deadbeef12345600f0", msg0);
    end
  endtask

  task automatic test_write_error_stall();
    run_frame(1'b0, 1'b1, 24'h000010, 32'h00000055, 1'b1, 1, 1'b0, "write_err_stall");
    checks++;
    if (msg0 !== 96'h0F0002000000550000100_1F0) begin
      failures++;
      $display("FAIL write_msg_const got=%h want=0f000200000055000010 01f0", msg0);
    end
  endtask

  task automatic test_invalid_op();
    run_frame(1'b1, 1'b1, 24'hABCDEF, 32'h01234567, 1'b0, 2, 1'b0, "invalid_both");
    checks++;
    if ({msg0[87:72], msg0[15:8]} !== 24'h000001) begin
      failures++;
      $display("FAIL invalid_both_fields got=%h want=000001", {msg0[87:72], msg0[15:8]});
    end
    run_frame(1'b0, 1'b0, 24'h00FF00, 32'hCAFEF00D, 1'b0, 2, 1'b0, "invalid_none");
    checks++;
    if ({msg0[87:72], msg0[15:8]} !== 24'h000001) begin
      failures++;
      $display("FAIL invalid_none_fields got=%h want=000001", {msg0[87:72], msg0[15:8]});
    end
  endtask

  task automatic test_busy();
    run_frame(1'b1, 1'b0, 24'h55AA55, 32'h13579BDF, 1'b0, 2, 1'b1, "busy_first");
    run_frame(1'b0, 1'b1, 24'h0F0F0F, 32'h2468ACE0, 1'b0, 0, 1'b0, "busy_second");
  endtask

  task automatic test_back_to_back();
    run_frame(1'b1, 1'b0, 24'h000001, 32'h00000001, 1'b0, 0, 1'b0, "b2b_a");
    run_frame(1'b0, 1'b1, 24'hFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1'b0, "b2b_b");
  endtask

  task automatic test_gap();
    logic [95:0] exp;
    int cyc;
    rd = 1'b1; wr = 1'b0; addr = 24'h3C3C3C; data = 32'h87654321; err = 1'b0;
    exp = model_frame(1'b1, 1'b0, 24'h3C3C3C, 32'h87654321, 1'b0);
    tx_ready = 1'b1;
    req3 = 1'b1;
    cyc = 0;
    while (done3 !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done3 !== 1'b1) begin
      failures++;
      $display("FAIL gap_first_done got=%b want=1", done3);
    end
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j <= 3) begin
        checks++;
        if ({ready3, busy3, done3, txv3} !== 4'b0100) begin
          failures++;
          $display("FAIL gap_cycle%0d rdy/busy/done/valid got=%b want=0100", j,
                   {ready3, busy3, done3, txv3});
        end
      end else if (j == 4) begin
        checks++;
        if ({ready3, busy3, txv3} !== 3'b100) begin
          failures++;
          $display("FAIL gap_idle rdy/busy/valid got=%b want=100", {ready3, busy3, txv3});
        end
      end else begin
        checks++;
        if ({txv3, txb3, msg3} !== {1'b1, 8'h0F, exp}) begin
          failures++;
          $display("FAIL gap_next_first got=%b/%h/%h want=1/0f/%h", txv3, txb3, msg3, exp);
        end
      end
    end
    req3 = 1'b0;
    cyc = 0;
    while (ready3 !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ready3 !== 1'b1) begin
      failures++;
      $display("FAIL gap_drain ready got=%b want=1", ready3);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [95:0] exp;
    exp = model_frame(1'b0, 1'b1, 24'h777777, 32'h11223344, 1'b0);
    rd = 1'b0; wr = 1'b1; addr = 24'h777777; data = 32'h11223344; err = 1'b0;
    req0 = 1'b1;
    tx_ready = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({txv0, txb0} !== {1'b1, frame_byte(exp, 5)}) begin
      failures++;
      $display("FAIL rst_pre_byte5 got=%b/%h want=1/%h", txv0, txb0, frame_byte(exp, 5));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready0, txv0, busy0, done0, txb0, msg0} !== {4'b1000, 8'h00, 96'h0}) begin
      failures++;
      $display("FAIL rst_async got rdy=%b v=%b b=%b d=%b byte=%h msg=%h want 1,0,0,0,00,0",
               ready0, txv0, busy0, done0, txb0, msg0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b1, 1'b0, 24'h987654, 32'h0BADF00D, 1'b1, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_frame(1'($urandom), 1'($urandom), 24'($urandom), $urandom, 1'($urandom),
                2, 1'b0, "random");
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    req0 = 1'b0; req3 = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; data = '0; err = 1'b0; tx_ready = 1'b0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_read_frame();
    test_write_error_stall();
    test_invalid_op();
    test_busy();
    test_back_to_back();
    test_gap();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
